// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between two byte requesters, with accept timeout
module uart_tx_arbiter #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  input  logic       transmit_ready,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       grant_id,
  input  logic       err_clear,
  output logic       err_timeout
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [7:0] tx_byte_n;
  logic last_grant, last_grant_n, tx_ctrl_n, req0_ready_n, req1_ready_n, grant_id_n, err_n, win;
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= 1'b1;
      tx_ctrl     <= 1'b0;
      tx_byte     <= 8'h00;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_grant  <= last_grant_n;
      tx_ctrl     <= tx_ctrl_n;
      tx_byte     <= tx_byte_n;
      req0_ready  <= req0_ready_n;
      req1_ready  <= req1_ready_n;
      busy        <= state_n != IDLE;
      grant_id    <= grant_id_n;
      err_timeout <= err_n;
    end
  end
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cnt_inc      = cnt + 1'b1;
    last_grant_n = last_grant;
    tx_ctrl_n    = 1'b0;
    tx_byte_n    = tx_byte;
    req0_ready_n = 1'b0;
    req1_ready_n = 1'b0;
    grant_id_n   = grant_id;
    err_n        = err_clear ? 1'b0 : err_timeout;
    // on a tie the requester that did not go last wins
    win          = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    case (state)
      IDLE: if (transmit_ready && (req0_valid || req1_valid)) begin
        state_n      = ISSUE;
        tx_ctrl_n    = 1'b1;
        req0_ready_n = ~win;
        req1_ready_n = win;
        grant_id_n   = win;
        tx_byte_n    = win ? req1_byte : req0_byte;
      end
      ISSUE: begin
        state_n   = WAIT_ACCEPT;
        tx_ctrl_n = 1'b1;
        cnt_n     = '0;
      end
      WAIT_ACCEPT: if (!transmit_ready) state_n = WAIT_DONE;
      else if (cnt_inc == CW'(ACK_TIMEOUT)) begin
        state_n      = IDLE;
        cnt_n        = cnt_inc;
        err_n        = 1'b1;
        last_grant_n = grant_id;
      end else begin
        cnt_n     = cnt_inc;
        tx_ctrl_n = 1'b1;
      end
      WAIT_DONE: if (transmit_ready) begin
        state_n      = IDLE;
        last_grant_n = grant_id;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
